// File: rtl/pipe_pkg.sv
// Shared pipeline bundle definitions: stage payload widths, field offsets and pack/unpack helpers.
`timescale 1ns/1ps
package pipe_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam int unsigned IF_ID_W  = 2 * XLEN;
    localparam int unsigned ID_EX_W  = 5 * XLEN + 3 * REG_W;
    localparam int unsigned EX_MEM_W = 3 * XLEN + REG_W;
    localparam int unsigned MEM_WB_W = 2 * XLEN + REG_W;

    // ID/EX field offsets, LSB-first, matching id_ex_t below
    localparam int unsigned ID_EX_RD_LSB    = 0;
    localparam int unsigned ID_EX_RS2_LSB   = ID_EX_RD_LSB + REG_W;
    localparam int unsigned ID_EX_RS1_LSB   = ID_EX_RS2_LSB + REG_W;
    localparam int unsigned ID_EX_IMM_LSB   = ID_EX_RS1_LSB + REG_W;
    localparam int unsigned ID_EX_RD2_LSB   = ID_EX_IMM_LSB + XLEN;
    localparam int unsigned ID_EX_RD1_LSB   = ID_EX_RD2_LSB + XLEN;
    localparam int unsigned ID_EX_INSTR_LSB = ID_EX_RD1_LSB + XLEN;
    localparam int unsigned ID_EX_PC_LSB    = ID_EX_INSTR_LSB + XLEN;

    localparam int unsigned IF_ID_INSTR_LSB = 0;
    localparam int unsigned IF_ID_PC_LSB    = XLEN;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  store_data;
        logic [REG_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  wb_data;
        logic [REG_W-1:0] rd;
    } mem_wb_t;

    function automatic logic [IF_ID_W-1:0] pack_if_id(input if_id_t b);
        return b;
    endfunction

    function automatic if_id_t unpack_if_id(input logic [IF_ID_W-1:0] v);
        return if_id_t'(v);
    endfunction

    function automatic logic [ID_EX_W-1:0] pack_id_ex(input id_ex_t b);
        return b;
    endfunction

    function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] v);
        return id_ex_t'(v);
    endfunction

    function automatic logic [EX_MEM_W-1:0] pack_ex_mem(input ex_mem_t b);
        return b;
    endfunction

    function automatic ex_mem_t unpack_ex_mem(input logic [EX_MEM_W-1:0] v);
        return ex_mem_t'(v);
    endfunction

    function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input mem_wb_t b);
        return b;
    endfunction

    function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] v);
        return mem_wb_t'(v);
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register for one pipeline entry: async reset, optional sync clear, load enable.
`timescale 1ns/1ps
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = ID_EX_W,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_clear && CLEAR_DATA) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage register with flush; PIPE_STAGE_SKID_EN adds a skid entry
// so in_ready becomes a register output.
`timescale 1ns/1ps
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = ID_EX_W,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              r_main_valid;
    logic              w_main_valid_d;
    logic              w_main_load;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [DATA_W-1:0] w_main_src;
    logic [1:0]        r_occ;
    logic [1:0]        w_occ_d;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic              w_skid_valid_d;
    logic              w_skid_load;
    logic [DATA_W-1:0] w_skid_data;

    assign in_ready = !r_skid_valid;

    always_comb begin
        w_main_valid_d = r_main_valid;
        w_skid_valid_d = r_skid_valid;
        w_main_load    = 1'b0;
        w_skid_load    = 1'b0;
        if (clear) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (r_skid_valid) begin
            // in_ready is low here, so the only move is skid -> main on consumption
            if (w_out_xfer) begin
                w_main_load    = 1'b1;
                w_skid_valid_d = 1'b0;
            end
        end else if (w_in_xfer) begin
            if (r_main_valid && !out_ready) begin
                w_skid_load    = 1'b1;
                w_skid_valid_d = 1'b1;
            end else begin
                w_main_load    = 1'b1;
                w_main_valid_d = 1'b1;
            end
        end else if (w_out_xfer) begin
            w_main_valid_d = 1'b0;
        end
    end

    assign w_main_src = r_skid_valid ? w_skid_data : in_data;
    assign w_occ_d    = {1'b0, w_main_valid_d} + {1'b0, w_skid_valid_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_valid <= 1'b0;
        end else begin
            r_skid_valid <= w_skid_valid_d;
        end
    end

    pipe_data_reg #(
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid_reg (
        .clk     (clk),
        .reset   (reset),
        .i_clear (clear),
        .i_load  (w_skid_load),
        .i_data  (in_data),
        .o_data  (w_skid_data)
    );
`else
    assign in_ready = !r_main_valid || out_ready;

    always_comb begin
        w_main_load    = w_in_xfer && !clear;
        w_main_valid_d = r_main_valid;
        if (clear) begin
            w_main_valid_d = 1'b0;
        end else if (w_in_xfer) begin
            w_main_valid_d = 1'b1;
        end else if (w_out_xfer) begin
            w_main_valid_d = 1'b0;
        end
    end

    assign w_main_src = in_data;
    assign w_occ_d    = {1'b0, w_main_valid_d};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_occ        <= 2'd0;
        end else begin
            r_main_valid <= w_main_valid_d;
            r_occ        <= w_occ_d;
        end
    end

    pipe_data_reg #(
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main_reg (
        .clk     (clk),
        .reset   (reset),
        .i_clear (clear),
        .i_load  (w_main_load),
        .i_data  (w_main_src),
        .o_data  (out_data)
    );

    assign out_valid = r_main_valid;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: vector table, directed corner sequences, random run vs queue model.
`timescale 1ns/1ps
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int unsigned DW            = ID_EX_W;
    localparam bit          TB_CLEAR_DATA = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] q[$];

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_occ;
    } vec_t;

    vec_t vecs[10];

    pipe_stage_elastic #(
        .DATA_W     (DW),
        .CLEAR_DATA (TB_CLEAR_DATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    initial begin
        logic exp_ready;
        logic do_pop;
        logic do_push;
        logic [DW-1:0] pre_data;

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, DW'(i + 1), 1'b1, DW'(i + 1), 2'd1};
        end
        vecs[8] = '{1'b0, '0, 1'b0, '0, 2'd0};
        vecs[9] = '{1'b1, DW'(32'h55), 1'b1, DW'(32'h55), 2'd1};

        #12;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, '0);
        chk("reset_occ", occupancy, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);

        // Stream: one value per cycle, out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = vecs[i].in_valid;
            in_data  = vecs[i].in_data;
            #1;
            chk("stream_in_ready", in_ready, 1'b1);
            tick();
            chk("stream_out_valid", out_valid, vecs[i].exp_valid);
            chk("stream_occ", occupancy, vecs[i].exp_occ);
            if (vecs[i].exp_valid) chk("stream_out_data", out_data, vecs[i].exp_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tick();
        chk("stream_drained", out_valid, 1'b0);

        // Stall with 0xA then 0xB
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'hA);
        tick();
        chk("stall_a_valid", out_valid, 1'b1);
        chk("stall_a_data", out_data, DW'(32'hA));
        @(negedge clk);
        in_data = DW'(32'hB);
`ifdef PIPE_STAGE_SKID_EN
        #1;
        chk("stall_skid_accepts_b", in_ready, 1'b1);
        tick();
        chk("stall_hold_a", out_data, DW'(32'hA));
        chk("stall_occ2", occupancy, 2'd2);
        chk("stall_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("stall_rel_a", out_data, DW'(32'hA));
        tick();
`else
        #1;
        chk("stall_b_blocked", in_ready, 1'b0);
        tick();
        chk("stall_hold_a", out_data, DW'(32'hA));
        chk("stall_occ1", occupancy, 2'd1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("stall_b_now_ready", in_ready, 1'b1);
        tick();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
`endif
        chk("stall_b_valid", out_valid, 1'b1);
        chk("stall_b_data", out_data, DW'(32'hB));
        chk("stall_b_occ", occupancy, 2'd1);
        tick();
        chk("stall_empty", out_valid, 1'b0);

        // Clear while holding 0xC with 0xD arriving
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'hC);
        tick();
        chk("clear_hold_c", out_data, DW'(32'hC));
        @(negedge clk);
        clear = 1'b1; in_data = DW'(32'hD);
        tick();
        chk("clear_out_valid", out_valid, 1'b0);
        chk("clear_occ", occupancy, 2'd0);
        chk("clear_data", out_data, TB_CLEAR_DATA ? DW'(0) : DW'(32'hC));
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        tick();
        chk("clear_no_d", out_valid, 1'b0);

        // Async reset while full
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(32'h11);
        tick();
        @(negedge clk);
        in_data = DW'(32'h22);
        tick();
        chk("rst_pre_occ", occupancy, 2'(CAP));
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_out_data", out_data, '0);
        chk("rst_mid_occ", occupancy, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rel_in_ready", in_ready, 1'b1);
        chk("rst_rel_occ", occupancy, 2'd0);

        // Random traffic against a queue model of capacity CAP
        do_reset();
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            chk("rnd_out_valid", out_valid, q.size() > 0);
            chk("rnd_occ", occupancy, 2'(q.size()));
            if (q.size() > 0) chk("rnd_out_data", out_data, q[0]);
            pre_data  = out_data;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd_data();
            out_ready = ((c / 1000) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                              : ($urandom_range(0, 3) == 0);
            clear     = ($urandom_range(0, 99) == 0);
            #1;
`ifdef PIPE_STAGE_SKID_EN
            exp_ready = (q.size() < 2);
            chk("rnd_in_ready", in_ready, exp_ready);
            out_ready = ~out_ready;
            #1;
            chk("rnd_ready_indep", in_ready, exp_ready);
            out_ready = ~out_ready;
            #1;
`else
            exp_ready = (q.size() == 0) || out_ready;
            chk("rnd_in_ready", in_ready, exp_ready);
`endif
            if (q.size() > 0 && !out_ready) chk("rnd_stall_stable", out_data, pre_data);
            do_pop  = (q.size() > 0) && out_ready;
            do_push = in_valid && exp_ready;
            if (clear) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(in_data);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("drain_data", out_data, q[0]);
                void'(q.pop_front());
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
